// File: rtl/hazard_scheduler.sv
// Pipeline hazard controller: EX/MEM/WB writer scoreboard, operand forwarding,
// load-use bubbles, mispredict flushes and memory-wait freezes. Optional perf counters: HAZARD_PERF_CNT_EN.
module hazard_scheduler #(
    parameter int LOAD_USE_CYCLES = 1,
    parameter int FLUSH_CYCLES    = 1,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_src1,
    input  logic [4:0]       id_src2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic [4:0]       id_dest,
    input  logic             id_wr,
    input  logic             id_load,
    input  logic             ex_mispredict,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             fwd_depends_1,
    output logic             fwd_depends_2,
    output logic             fwd_stalls_1,
    output logic             fwd_stalls_2,
    output logic [1:0]       fwd_sel_1,
    output logic [1:0]       fwd_sel_2,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_freeze
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_stall_cnt,
    output logic [CNT_W-1:0] perf_flush_cnt
`endif
);

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       load;
    } sb_entry_t;

    typedef enum logic {RUN, FLUSH} state_t;

    genvar gi;
    genvar si;

    sb_entry_t  sb_q [3];
    sb_entry_t  sb_d [3];
    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       pend_q, pend_d;

    logic       freeze;
    logic       redirect;
    logic       pc_write_c, ifid_write_c, flush_c, bubble_c;
    logic [4:0] src_v [2];
    logic [1:0] use_v;
    logic [1:0] dep_v, stl_v;
    logic [1:0] sel_v [2];

    assign src_v[0] = id_src1;
    assign src_v[1] = id_src2;
    assign use_v    = {id_use2, id_use1};

    // Per-operand lookup; stage 0 (EX) is the youngest writer and wins.
    for (gi = 0; gi < 2; gi++) begin : g_fwd
        logic [2:0] hit;
        logic [2:0] late;
        logic [1:0] sel;
        logic       stl;

        for (si = 0; si < 3; si++) begin : g_stage
            assign hit[si]  = sb_q[si].valid && (sb_q[si].dest == src_v[gi]);
            assign late[si] = sb_q[si].load && (si < LOAD_USE_CYCLES);
        end

        always_comb begin
            sel = 2'b00;
            stl = 1'b0;
            if (dep_v[gi]) begin
                if (hit[0]) begin
                    sel = 2'b01;
                    stl = late[0];
                end else if (hit[1]) begin
                    sel = 2'b10;
                    stl = late[1];
                end else begin
                    sel = 2'b11;
                    stl = late[2];
                end
            end
        end

        assign dep_v[gi] = use_v[gi] && (src_v[gi] != 5'd0) && (|hit);
        assign stl_v[gi] = stl;
        assign sel_v[gi] = sel;
    end

    assign freeze   = mem_req && !mem_ack;
    assign redirect = ex_mispredict || pend_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pend_d       = pend_q;
        pc_write_c   = 1'b1;
        ifid_write_c = 1'b1;
        flush_c      = 1'b0;
        bubble_c     = 1'b0;
        if (freeze) begin
            pc_write_c   = 1'b0;
            ifid_write_c = 1'b0;
            if (ex_mispredict) pend_d = 1'b1;
        end else if (redirect) begin
            // A new redirect (also one arriving mid-flush) restarts the flush window.
            flush_c  = 1'b1;
            bubble_c = 1'b1;
            pend_d   = 1'b0;
            if (FLUSH_CYCLES > 1) begin
                state_d = FLUSH;
                cnt_d   = 2'(FLUSH_CYCLES - 2);
            end else begin
                state_d = RUN;
            end
        end else if (state_q == FLUSH) begin
            flush_c  = 1'b1;
            bubble_c = 1'b1;
            if (cnt_q == 2'd0) state_d = RUN;
            else               cnt_d   = cnt_q - 2'd1;
        end else if (|stl_v) begin
            pc_write_c   = 1'b0;
            ifid_write_c = 1'b0;
            bubble_c     = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) sb_d[i] = sb_q[i];
        if (!freeze) begin
            sb_d[2] = sb_q[1];
            sb_d[1] = sb_q[0];
            sb_d[0] = '0;
            if (id_valid && id_wr && (id_dest != 5'd0) && !bubble_c && !flush_c) begin
                sb_d[0].valid = 1'b1;
                sb_d[0].dest  = id_dest;
                sb_d[0].load  = id_load;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) sb_q[i] <= '0;
            state_q <= RUN;
            cnt_q   <= 2'd0;
            pend_q  <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) sb_q[i] <= sb_d[i];
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    // Controls are forced to their idle values while reset is asserted.
    assign pc_write      = !rst_n || pc_write_c;
    assign ifid_write    = !rst_n || ifid_write_c;
    assign ifid_flush    = rst_n && flush_c;
    assign idex_bubble   = rst_n && bubble_c;
    assign pipe_freeze   = rst_n && freeze;
    assign fwd_depends_1 = rst_n && dep_v[0];
    assign fwd_depends_2 = rst_n && dep_v[1];
    assign fwd_stalls_1  = rst_n && stl_v[0];
    assign fwd_stalls_2  = rst_n && stl_v[1];
    assign fwd_sel_1     = rst_n ? sel_v[0] : 2'b00;
    assign fwd_sel_2     = rst_n ? sel_v[1] : 2'b00;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (bubble_c && !flush_c && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
        if (flush_c && !(&flush_cnt_q))              flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule
